// File: rtl/pulse_gen_pkg.sv
// Shared types and default widths for the pulse train stimulus generator.
package pulse_gen_pkg;

   localparam int DEF_CNT_W = 8;
   localparam int DEF_NUM_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2,
      FIN  = 2'd3
   } state_t;

endpackage

// File: rtl/phase_counter.sv
// Loadable down-counter timing one high or low phase of the pulse train.
module phase_counter
   import pulse_gen_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   output logic             zero
);

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] cnt;

   // Load wins over counting; the count parks at zero until the next load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - ONE;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Programmable pulse train source driving the input of a delay chain under test.
module pulse_train_gen
   import pulse_gen_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W,
   parameter int NUM_W = DEF_NUM_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] high_len,
   input  logic [CNT_W-1:0] low_len,
   input  logic [NUM_W-1:0] num_pulses,
   output logic             pulse_out,
   output logic             busy,
   output logic             done,
   output logic [NUM_W-1:0] pulses_sent
);

   localparam logic [CNT_W-1:0] ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [NUM_W-1:0] ONE_N = {{(NUM_W-1){1'b0}}, 1'b1};

   state_t           state;
   logic [CNT_W-1:0] high_lat;
   logic [CNT_W-1:0] low_lat;
   logic [NUM_W-1:0] num_lat;

   logic             go_high;
   logic             go_low;
   logic             ph_load;
   logic             ph_en;
   logic             ph_zero;
   logic [CNT_W-1:0] ph_val;

   // A zero length behaves as one cycle; the counter holds length minus one.
   function automatic logic [CNT_W-1:0] eff_m1(input logic [CNT_W-1:0] len);
      return (len == '0) ? '0 : (len - ONE_C);
   endfunction

   // Phase-entry decisions and the reload value for the phase counter.
   always_comb begin
      go_high = 1'b0;
      go_low  = 1'b0;
      ph_val  = '0;
      case (state)
         IDLE:    go_high = start && (num_pulses != '0);
         HIGH:    go_low  = !abort && ph_zero;
         LOW:     go_high = !abort && ph_zero && (pulses_sent < num_lat);
         default: ;
      endcase
      // In IDLE the fields are being latched this edge, so use the live inputs.
      if (state == IDLE) begin
         ph_val = eff_m1(high_len);
      end else if (go_high) begin
         ph_val = eff_m1(high_lat);
      end else begin
         ph_val = eff_m1(low_lat);
      end
      ph_load = go_high || go_low;
      ph_en   = (state == HIGH) || (state == LOW);
   end

   phase_counter #(
      .CNT_W (CNT_W)
   ) u_phase_counter (
      .clk      (clk),
      .rst      (rst),
      .load     (ph_load),
      .load_val (ph_val),
      .en       (ph_en),
      .zero     (ph_zero)
   );

   // Run FSM with registered outputs; abort outranks any phase transition.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         pulse_out   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         pulses_sent <= '0;
         high_lat    <= '0;
         low_lat     <= '0;
         num_lat     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  high_lat <= high_len;
                  low_lat  <= low_len;
                  num_lat  <= num_pulses;
                  if (num_pulses != '0) begin
                     state       <= HIGH;
                     pulse_out   <= 1'b1;
                     busy        <= 1'b1;
                     pulses_sent <= ONE_N;
                  end else begin
                     state       <= FIN;
                     done        <= 1'b1;
                     pulses_sent <= '0;
                  end
               end
            end
            HIGH: begin
               if (abort) begin
                  state     <= IDLE;
                  pulse_out <= 1'b0;
                  busy      <= 1'b0;
               end else if (go_low) begin
                  state     <= LOW;
                  pulse_out <= 1'b0;
               end
            end
            LOW: begin
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (go_high) begin
                  state       <= HIGH;
                  pulse_out   <= 1'b1;
                  pulses_sent <= pulses_sent + ONE_N;
               end else if (ph_zero) begin
                  state <= FIN;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            FIN: begin
               state <= IDLE;
            end
            default: begin
               state     <= IDLE;
               pulse_out <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench for pulse_train_gen against a cycle-index reference model.
module tb_pulse_train_gen;

   localparam int CNT_W = 8;
   localparam int NUM_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             abort;
   logic [CNT_W-1:0] high_len;
   logic [CNT_W-1:0] low_len;
   logic [NUM_W-1:0] num_pulses;
   logic             pulse_out;
   logic             busy;
   logic             done;
   logic [NUM_W-1:0] pulses_sent;

   int total = 0;
   int bad   = 0;

   pulse_train_gen #(
      .CNT_W (CNT_W),
      .NUM_W (NUM_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .abort       (abort),
      .high_len    (high_len),
      .low_len     (low_len),
      .num_pulses  (num_pulses),
      .pulse_out   (pulse_out),
      .busy        (busy),
      .done        (done),
      .pulses_sent (pulses_sent)
   );

   always #5 clk = ~clk;

   // Expected {pulse_out, busy, done, pulses_sent} in cycle k after the start edge.
   function automatic logic [NUM_W+2:0] model(input int h, input int l, input int n, input int k);
      int he, le, per, len;
      logic [NUM_W-1:0] s;
      he  = (h == 0) ? 1 : h;
      le  = (l == 0) ? 1 : l;
      per = he + le;
      len = n * per;
      if (k <= len) begin
         s = NUM_W'((k - 1) / per + 1);
         return {(((k - 1) % per) < he), 1'b1, 1'b0, s};
      end
      if (k == len + 1) return {1'b0, 1'b0, 1'b1, NUM_W'(n)};
      return {1'b0, 1'b0, 1'b0, NUM_W'(n)};
   endfunction

   // One run: start at an edge, compare every following cycle, optional abort/noise.
   task automatic run_check(input string name, input int h, input int l, input int n,
                            input int abort_k, input bit noise);
      int he, le, len, last;
      logic [NUM_W+2:0] exp_v, obs_v, abort_v;
      he  = (h == 0) ? 1 : h;
      le  = (l == 0) ? 1 : l;
      len = n * (he + le);
      last = (abort_k > 0) ? abort_k : len + 1;
      abort_v = (abort_k > 0) ? model(h, l, n, abort_k) : '0;
      @(negedge clk);
      high_len   = CNT_W'(h);
      low_len    = CNT_W'(l);
      num_pulses = NUM_W'(n);
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k <= last + 3; k++) begin
         if (abort_k > 0 && k > abort_k)
            exp_v = {1'b0, 1'b0, 1'b0, abort_v[NUM_W-1:0]};
         else
            exp_v = model(h, l, n, k);
         obs_v = {pulse_out, busy, done, pulses_sent};
         total++;
         if (obs_v !== exp_v) begin
            bad++;
            $display("FAIL %s cycle %0d: got pulse/busy/done/sent=%b/%b/%b/%0d want %b/%b/%b/%0d",
                     name, k, obs_v[NUM_W+2], obs_v[NUM_W+1], obs_v[NUM_W], obs_v[NUM_W-1:0],
                     exp_v[NUM_W+2], exp_v[NUM_W+1], exp_v[NUM_W], exp_v[NUM_W-1:0]);
         end
         abort = (abort_k > 0 && k == abort_k);
         if (noise && k <= last) begin
            high_len   = CNT_W'($urandom);
            low_len    = CNT_W'($urandom);
            num_pulses = NUM_W'($urandom);
            start      = $urandom_range(0, 1) != 0;
            if (abort_k == 0 && k == len + 1) start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      abort = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      total++;
      if ({pulse_out, busy, done, pulses_sent} !== '0) begin
         bad++;
         $display("FAIL reset_hold: got %b/%b/%b/%0d want 0/0/0/0", pulse_out, busy, done, pulses_sent);
      end
      rst = 1'b0;
      @(negedge clk);
      total++;
      if ({pulse_out, busy, done, pulses_sent} !== '0) begin
         bad++;
         $display("FAIL reset_release: got %b/%b/%b/%0d want 0/0/0/0", pulse_out, busy, done, pulses_sent);
      end
   endtask

   task automatic test_basic();
      run_check("basic", 3, 2, 2, 0, 1'b0);
   endtask

   task automatic test_zero_len();
      run_check("zero_len", 0, 0, 4, 0, 1'b0);
   endtask

   task automatic test_empty();
      run_check("empty", 4, 4, 0, 0, 1'b0);
   endtask

   task automatic test_abort();
      // Second high cycle of pulse 2: period 10, so cycle 12 after start.
      run_check("abort", 5, 5, 3, 12, 1'b0);
      // Abort during a low phase and on a phase-boundary cycle.
      run_check("abort_low", 2, 3, 3, 5, 1'b0);
      run_check("abort_edge", 2, 2, 2, 2, 1'b0);
   endtask

   task automatic test_ignored();
      // Inputs scrambled and start toggled mid-run, start forced in the FIN cycle.
      run_check("ignored", 3, 2, 2, 0, 1'b1);
      run_check("ignored_abort", 4, 1, 3, 9, 1'b1);
   endtask

   task automatic test_reset_midrun();
      @(negedge clk);
      high_len   = 8'd4;
      low_len    = 8'd3;
      num_pulses = 8'd3;
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      total++;
      if (pulse_out !== 1'b1) begin
         bad++;
         $display("FAIL pre_reset_pulse: got %b want 1", pulse_out);
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if ({pulse_out, busy, done, pulses_sent} !== '0) begin
         bad++;
         $display("FAIL async_reset: got %b/%b/%b/%0d want 0/0/0/0", pulse_out, busy, done, pulses_sent);
      end
      @(negedge clk);
      rst = 1'b0;
      run_check("after_reset", 1, 1, 3, 0, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 8; i++) begin
         int h, l, n, per, ak;
         h   = $urandom_range(0, 5);
         l   = $urandom_range(0, 5);
         n   = $urandom_range(0, 4);
         per = ((h == 0) ? 1 : h) + ((l == 0) ? 1 : l);
         ak  = 0;
         if (n > 0 && $urandom_range(0, 2) == 0) ak = $urandom_range(1, n * per);
         run_check("random", h, l, n, ak, $urandom_range(0, 1) != 0);
      end
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      abort      = 1'b0;
      high_len   = '0;
      low_len    = '0;
      num_pulses = '0;
      test_reset();
      test_basic();
      test_zero_len();
      test_empty();
      test_abort();
      test_ignored();
      test_reset_midrun();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
